// File: rtl/wbu_pkg.sv
// Shared writeback-unit types: load funct3 codes, FIFO depth and the buffered entry layout.
package wbu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 2;

    typedef enum logic [2:0] {
        F3_LB  = 3'd0,
        F3_LH  = 3'd1,
        F3_LW  = 3'd2,
        F3_LBU = 3'd4,
        F3_LHU = 3'd5
    } ld_funct3_e;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic            we;
        logic [XLEN-1:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wbu_load_fmt.sv
// Load data formatter: picks byte/half/word from the aligned LSU word and sign/zero-extends it.
module wbu_load_fmt
    import wbu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    always_comb begin
        shifted  = word >> {addr_lo, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        data     = '0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   data = word;
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wbu.sv
// Writeback unit: 2-entry retire FIFO, registered regfile write port and RAW pending scoreboard.
// Optional WBU_BYPASS_EN exposes the landing write as a forward path and relaxes hazards.
module wbu
    import wbu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_rd_we,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu_res,
    input  logic [XLEN-1:0] in_load_word,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic            hazard1,
    output logic            hazard2,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            commit,
    output logic            fwd1_valid,
    output logic            fwd2_valid,
    output logic [XLEN-1:0] fwd_data
);

    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam int unsigned   NREG     = 1 << AW;
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    wb_entry_t       fifo_q [DEPTH];
    wb_entry_t       fifo_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            rf_we_q, rf_we_d, commit_q, commit_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [1:0]      sb_q [NREG];
    logic [1:0]      sb_d [NREG];
    logic [NREG-1:0] inc_vec, dec_vec;
    logic            push, pop;
    logic [XLEN-1:0] load_data;
    wb_entry_t       head;
    logic [1:0]      cnt1, cnt2;

    wbu_load_fmt u_load_fmt (
        .funct3  (in_funct3),
        .addr_lo (in_addr_lo),
        .word    (in_load_word),
        .data    (load_data)
    );

    // No pass-through: a full FIFO refuses input even while it pops.
    always_comb begin
        in_ready = (count_q != FULL_CNT);
        push     = in_valid && in_ready;
        pop      = (count_q != '0);
        head     = fifo_q[rd_ptr_q];
        fifo_d   = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q].rd    = in_rd;
            fifo_d[wr_ptr_q].we    = in_rd_we;
            fifo_d[wr_ptr_q].wdata = in_is_load ? load_data : in_alu_res;
        end
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
        rf_we_d    = pop && head.we && (head.rd != '0);
        rf_waddr_d = pop ? head.rd : rf_waddr_q;
        rf_wdata_d = pop ? head.wdata : rf_wdata_q;
        commit_d   = pop;
    end

    // Decrements come from the write actually landing on the registered port.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_valid && (issue_rd != '0)) inc_vec[issue_rd] = 1'b1;
        if (rf_we_q) dec_vec[rf_waddr_q] = 1'b1;
        sb_d = sb_q;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (inc_vec[r] && !dec_vec[r]) begin
                sb_d[r] = sb_q[r] + 2'd1;
            end else if (dec_vec[r] && !inc_vec[r] && (sb_q[r] != 2'd0)) begin
                sb_d[r] = sb_q[r] - 2'd1;
            end
        end
    end

    always_comb begin
        cnt1 = sb_q[raddr1];
        cnt2 = sb_q[raddr2];
`ifdef WBU_BYPASS_EN
        fwd1_valid = rf_we_q && (rf_waddr_q == raddr1) && (raddr1 != '0);
        fwd2_valid = rf_we_q && (rf_waddr_q == raddr2) && (raddr2 != '0);
        fwd_data   = rf_wdata_q;
        hazard1    = (raddr1 != '0) && (cnt1 != 2'd0) && !(fwd1_valid && (cnt1 == 2'd1));
        hazard2    = (raddr2 != '0) && (cnt2 != 2'd0) && !(fwd2_valid && (cnt2 == 2'd1));
`else
        fwd1_valid = 1'b0;
        fwd2_valid = 1'b0;
        fwd_data   = '0;
        hazard1    = (raddr1 != '0) && (cnt1 != 2'd0);
        hazard2    = (raddr2 != '0) && (cnt2 != 2'd0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            commit_q   <= 1'b0;
            sb_q       <= '{default: '0};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            commit_q   <= commit_d;
            sb_q       <= sb_d;
            assert (!(issue_valid && (issue_rd != '0) && (sb_q[issue_rd] == 2'd3)));
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign commit   = commit_q;

endmodule

// File: tb/tb_wbu.sv
// Self-checking bench for wbu: retire scoreboard queue, load formatting, hazards, bypass, reset.
module tb_wbu;
    import wbu_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid, in_ready, in_rd_we, in_is_load;
    logic [AW-1:0]   in_rd;
    logic [2:0]      in_funct3;
    logic [1:0]      in_addr_lo;
    logic [XLEN-1:0] in_alu_res, in_load_word;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd, raddr1, raddr2;
    logic            hazard1, hazard2, rf_we, commit, fwd1_valid, fwd2_valid;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata, fwd_data;

    wbu dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_rd_we     (in_rd_we),
        .in_is_load   (in_is_load),
        .in_funct3    (in_funct3),
        .in_addr_lo   (in_addr_lo),
        .in_alu_res   (in_alu_res),
        .in_load_word (in_load_word),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .hazard1      (hazard1),
        .hazard2      (hazard2),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .commit       (commit),
        .fwd1_valid   (fwd1_valid),
        .fwd2_valid   (fwd2_valid),
        .fwd_data     (fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   rd;
        logic            we;
        logic [XLEN-1:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   occ_m = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fmt_model(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'h0000_00FF;
        h = a[1] ? (w >> 16) : (w & 32'h0000_FFFF);
        case (f3)
            3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    // Occupancy model: one pop per cycle whenever non-empty, push only below DEPTH.
    always @(posedge clk) begin
        if (rst) occ_m <= 0;
        else occ_m <= occ_m + ((in_valid && occ_m < int'(DEPTH)) ? 1 : 0) - ((occ_m != 0) ? 1 : 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 64'(in_ready), 64'(occ_m < int'(DEPTH)));
            if (commit) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wb_port", 64'({rf_we, rf_waddr, rf_wdata}),
                          64'({mon_e.we && (mon_e.rd != 5'd0), mon_e.rd, mon_e.wdata}));
                end
            end else begin
                check("rf_we_idle", 64'(rf_we), 64'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] rd, input logic we, input logic ld,
                         input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] alu,
                         input logic [31:0] word, input logic [31:0] exp_wd, input logic track);
        bit   done;
        exp_t e;
        done         = 1'b0;
        in_valid     = 1'b1;
        in_rd        = rd;
        in_rd_we     = we;
        in_is_load   = ld;
        in_funct3    = f3;
        in_addr_lo   = alo;
        in_alu_res   = alu;
        in_load_word = word;
        for (int i = 0; i < 8 && !done; i++) begin
            if (in_ready) begin
                if (track) begin
                    e.rd = rd; e.we = we; e.wdata = exp_wd;
                    exp_q.push_back(e);
                end
                done = 1'b1;
            end
            cyc();
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] w;
        logic [4:0]  rd;
        in_valid = 0; in_rd = 0; in_rd_we = 0; in_is_load = 0; in_funct3 = 0;
        in_addr_lo = 0; in_alu_res = 0; in_load_word = 0;
        issue_valid = 0; issue_rd = 0; raddr1 = 5'd7; raddr2 = 5'd9;

        repeat (3) cyc();
        rst = 1'b0;
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", 64'(rf_wdata), 64'd0);
        check("rst_commit", 64'(commit), 64'd0);
        check("rst_hazard1", 64'(hazard1), 64'd0);
        check("rst_hazard2", 64'(hazard2), 64'd0);
        check("rst_fwd", 64'({fwd1_valid, fwd2_valid, fwd_data}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // ALU write and its latency
        offer(5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234, 32'h0, 32'h1234, 1'b1);
        cyc();
        check("alu_port", 64'({commit, rf_we, rf_waddr, rf_wdata}), 64'({1'b1, 1'b1, 5'd5, 32'h1234}));

        // Loads from a fixed word
        offer(5'd1, 1'b1, 1'b1, 3'd0, 2'd2, 32'h0, 32'h80FF7F01, 32'hFFFFFFFF, 1'b1);
        offer(5'd2, 1'b1, 1'b1, 3'd4, 2'd3, 32'h0, 32'h80FF7F01, 32'h00000080, 1'b1);
        offer(5'd3, 1'b1, 1'b1, 3'd1, 2'd2, 32'h0, 32'h80FF7F01, 32'hFFFF80FF, 1'b1);
        offer(5'd4, 1'b1, 1'b1, 3'd2, 2'd1, 32'h0, 32'h80FF7F01, 32'h80FF7F01, 1'b1);
        offer(5'd6, 1'b1, 1'b1, 3'd5, 2'd0, 32'h0, 32'h80FF7F01, 32'h00007F01, 1'b1);
        offer(5'd8, 1'b1, 1'b1, 3'd3, 2'd0, 32'h5, 32'h80FF7F01, 32'h00000000, 1'b1);

        // x0 write and a non-writing instruction still commit
        offer(5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEAD, 32'h0, 32'hDEAD, 1'b1);
        offer(5'd6, 1'b0, 1'b0, 3'd0, 2'd0, 32'hBEEF, 32'h0, 32'hBEEF, 1'b1);
        raddr1 = 5'd0; issue_valid = 1'b1; issue_rd = 5'd0;
        cyc();
        issue_valid = 1'b0;
        check("x0_no_hazard", 64'(hazard1), 64'd0);

        // Back-to-back burst of three
        offer(5'd10, 1'b1, 1'b0, 3'd0, 2'd0, 32'hA0, 32'h0, 32'hA0, 1'b1);
        offer(5'd11, 1'b1, 1'b0, 3'd0, 2'd0, 32'hA1, 32'h0, 32'hA1, 1'b1);
        offer(5'd12, 1'b1, 1'b0, 3'd0, 2'd0, 32'hA2, 32'h0, 32'hA2, 1'b1);

        // Random loads with occasional gaps
        for (int i = 0; i < 16; i++) begin
            f3  = 3'($urandom_range(0, 7));
            alo = 2'($urandom_range(0, 3));
            w   = $urandom;
            rd  = 5'($urandom_range(1, 31));
            offer(rd, 1'b1, 1'b1, f3, alo, 32'h0, w, fmt_model(f3, alo, w), 1'b1);
            if ($urandom_range(0, 3) == 0) cyc();
        end
        repeat (4) cyc();

        // Two in-flight writes to x7
        raddr1 = 5'd7;
        issue_valid = 1'b1; issue_rd = 5'd7;
        cyc(); cyc();
        issue_valid = 1'b0;
        check("haz_cnt2", 64'(hazard1), 64'd1);
        offer(5'd7, 1'b1, 1'b0, 3'd0, 2'd0, 32'h77, 32'h0, 32'h77, 1'b1);
        check("haz_w1_queued", 64'(hazard1), 64'd1);
        offer(5'd7, 1'b1, 1'b0, 3'd0, 2'd0, 32'h78, 32'h0, 32'h78, 1'b1);
        check("haz_w1_land", 64'(hazard1), 64'd1);
        cyc();
`ifdef WBU_BYPASS_EN
        check("haz_w2_land", 64'(hazard1), 64'd0);
        check("fwd1_w2_land", 64'(fwd1_valid), 64'd1);
`else
        check("haz_w2_land", 64'(hazard1), 64'd1);
        check("fwd1_w2_land", 64'(fwd1_valid), 64'd0);
`endif
        cyc();
        check("haz_clear", 64'(hazard1), 64'd0);

        // Issue and write to x7 in the same cycle
        issue_valid = 1'b1; issue_rd = 5'd7;
        cyc();
        issue_valid = 1'b0;
        offer(5'd7, 1'b1, 1'b0, 3'd0, 2'd0, 32'h79, 32'h0, 32'h79, 1'b1);
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd7;
        cyc();
        issue_valid = 1'b0;
        check("haz_same_cycle", 64'(hazard1), 64'd1);
        offer(5'd7, 1'b1, 1'b0, 3'd0, 2'd0, 32'h7A, 32'h0, 32'h7A, 1'b1);
        cyc(); cyc();
        check("haz_after_last", 64'(hazard1), 64'd0);

        // Writeback to x9 with a single pending write
        raddr2 = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9;
        cyc();
        issue_valid = 1'b0;
        offer(5'd9, 1'b1, 1'b0, 3'd0, 2'd0, 32'h9999_0009, 32'h0, 32'h9999_0009, 1'b1);
        check("haz2_pending", 64'(hazard2), 64'd1);
        cyc();
`ifdef WBU_BYPASS_EN
        check("byp_fwd2", 64'({fwd2_valid, hazard2}), 64'({1'b1, 1'b0}));
        check("byp_data", 64'(fwd_data), 64'h9999_0009);
`else
        check("byp_fwd2", 64'({fwd2_valid, hazard2}), 64'({1'b0, 1'b1}));
        check("byp_data", 64'(fwd_data), 64'd0);
`endif
        cyc();
        check("byp_after", 64'({fwd2_valid, hazard2}), 64'd0);

        // Reset with an entry buffered and a write pending on x3
        repeat (3) cyc();
        raddr1 = 5'd3;
        issue_valid = 1'b1; issue_rd = 5'd3;
        offer(5'd12, 1'b1, 1'b0, 3'd0, 2'd0, 32'hC0C0, 32'h0, 32'hC0C0, 1'b0);
        issue_valid = 1'b0;
        check("haz_pre_rst", 64'(hazard1), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mid_rst_port", 64'({rf_we, commit, hazard1, in_ready}), 64'({1'b0, 1'b0, 1'b0, 1'b1}));
        cyc();
        check("mid_rst_no_write", 64'({rf_we, commit}), 64'd0);

        repeat (6) cyc();
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
